decode_dispatch_unit: RTL and testbench
=======================================

// Module: decode_dispatch_unit
// PURPOSE
//  RV32I front-end stage: combinational decoder, dispatcher, and a tagged 32x32 register file.
//  Takes raw instructions from instruction fetch, decodes op/rd/rs1/rs2/imm, reads operands and rename tags,
//  claims rd with a new tag, and issues one registered packet per cycle to the reservation station.
//  Commit writes return through the writeback port.
// PARAMETERS
//  TAG_W     4   rename-tag width; tags 1..2^TAG_W-1 used, 0 = "no tag / value ready"
//  OPENUM_W  6   op_enum width
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  inst_valid     in   1   inst_from_if holds a new instruction this cycle
//  inst_from_if   in   32  raw RV32I instruction word
//  rs_full        in   1   reservation station cannot accept; stall
//  dsp_ready      out  1   ~rs_full; an instruction is consumed when inst_valid & dsp_ready
//  dsp_valid      out  1   issue packet valid (one cycle per consumed instruction)
//  dsp_op_enum    out  6   decoded operation (enum below)
//  dsp_rd         out  5   destination register (0 if none)
//  dsp_imm        out  32  sign-extended / shifted immediate
//  dsp_rs1_val    out  32  rs1 value (valid when dsp_rs1_tag==0)
//  dsp_rs1_tag    out  4   rs1 pending tag, 0 = ready
//  dsp_rs2_val    out  32  rs2 value
//  dsp_rs2_tag    out  4   rs2 pending tag
//  dsp_rd_tag     out  4   tag assigned to rd (0 if rd==0)
//  wb_valid       in   1   commit write strobe
//  wb_rd          in   5   commit destination
//  wb_tag         in   4   tag of committing result
//  wb_value       in   32  committed value
// BEHAVIOUR
//  - Enum: NOP0 LUI1 AUIPC2 JAL3 JALR4 BEQ5 BNE6 BLT7 BGE8 BLTU9 BGEU10 LB11 LH12 LW13 LBU14 LHU15
//    SB16 SH17 SW18 ADDI19 SLTI20 SLTIU21 XORI22 ORI23 ANDI24 SLLI25 SRLI26 SRAI27 ADD28 SUB29 SLL30
//    SLT31 SLTU32 XOR33 SRL34 SRA35 OR36 AND37; unknown opcode/funct -> NOP (0), treated as no-op.
//  - Decode is purely combinational. Fields not used by a format are 0:
//    rd=0 for S/B; rs1=0 for U/J; rs2=0 for U/J/I.
//  - Imm encoding:
//    - U: inst[31:12]<<12.
//    - I/S: sign-ext 12b; SLLI/SRLI/SRAI use inst[24:20] zero-ext.
//    - B/J: sign-ext byte offset with bit 0 = 0.
//  - Dispatch latency 1: outputs registered; consumed inst appears on dsp_* next cycle with dsp_valid=1.
//  - Stall: while rs_full=1, no consumption; dsp_valid=0 and register/tag state unchanged.
//  - Regfile: x0 always reads 0, tag 0, never written or tagged.
//  - Operand read returns {value, tag}, with wb bypass: if wb_valid and wb_rd==rs and wb_tag==reg tag,
//    value=wb_value and tag=0.
//  - Tag allocation: on dispatch with rd!=0, rd.tag <= next_tag and dsp_rd_tag=next_tag.
//    next_tag increments and wraps 2^TAG_W-1 -> 1 (skipping 0).
//    Operands read before rd is claimed, so addi x2,x2 reads the old x2 tag.
//  - Writeback: rd.value <= wb_value always (wb_rd!=0); rd.tag <= 0 only if tag matches.
//    Same-cycle dispatch claiming rd wins over the tag clear.
//  - Reset (sync): all values 0, all tags 0, next_tag=1, dsp_valid=0, all dsp_* = 0.
//    Reset mid-stream discards the in-flight packet.
// TESTING
//  - 00020137 (lui sp,0x20) -> op 1, rd 2, rs1 0, rs2 0, imm 0x00020000, rd_tag 1.
//  - 02912223 (sw s1,36(sp)) -> op 18, rd 0, rs1 2, rs2 9, imm 36; rs1_tag 1 (from lui), rd_tag 0.
//  - fd010113 (addi sp,sp,-48) -> op 19, rd 2, rs1 2, imm 0xFFFFFFD0.
//  - fe891ae3 (bne s2,s0) -> op 6, rs1 18, rs2 8, imm -12; 02412483 (lw s1,36(sp)) -> op 13, rd 9, rs1 2, imm 36.
//  - fd3a46e3 (blt s4,s3) -> op 7, rs1 20, rs2 19, imm -52.
//    Then wb {rd=2, tag=latest, val=0x1234} -> x2 reads 0x1234, tag 0.
//  - rs_full=1 for 3 cycles -> dsp_valid=0, tags unchanged; 16 dispatches -> tag wraps 15 -> 1; rst -> all zero.

Source files
------------

// File: rtl/decode_dispatch_unit.sv
// RV32I decode/dispatch stage: combinational decoder, tagged 32x32 register file with
// writeback bypass, and a one-cycle registered issue packet toward the reservation station.
module decode_dispatch_unit #(
    parameter int TAG_W    = 4,
    parameter int OPENUM_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_valid,
    input  logic [31:0]         inst_from_if,
    input  logic                rs_full,
    output logic                dsp_ready,
    output logic                dsp_valid,
    output logic [OPENUM_W-1:0] dsp_op_enum,
    output logic [4:0]          dsp_rd,
    output logic [31:0]         dsp_imm,
    output logic [31:0]         dsp_rs1_val,
    output logic [TAG_W-1:0]    dsp_rs1_tag,
    output logic [31:0]         dsp_rs2_val,
    output logic [TAG_W-1:0]    dsp_rs2_tag,
    output logic [TAG_W-1:0]    dsp_rd_tag,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic [TAG_W-1:0]    wb_tag,
    input  logic [31:0]         wb_value
);

    typedef enum logic [OPENUM_W-1:0] {
        OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU,
        OP_BGEU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADDI, OP_SLTI,
        OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_ADD, OP_SUB, OP_SLL,
        OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    logic [31:0]      w_inst;
    logic [6:0]       w_opc;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    op_e              w_op;
    fmt_e             w_fmt;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [31:0]      w_imm;
    logic             w_fire;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic [31:0]      w_rs1_val;
    logic [31:0]      w_rs2_val;
    logic [TAG_W-1:0] w_rs1_tag;
    logic [TAG_W-1:0] w_rs2_tag;

    logic [31:0]      r_val [32];
    logic [TAG_W-1:0] r_tag [32];
    logic [TAG_W-1:0] r_next_tag;
    logic             r_dsp_valid;
    op_e              r_dsp_op;
    logic [4:0]       r_dsp_rd;
    logic [31:0]      r_dsp_imm;
    logic [31:0]      r_dsp_rs1_val;
    logic [TAG_W-1:0] r_dsp_rs1_tag;
    logic [31:0]      r_dsp_rs2_val;
    logic [TAG_W-1:0] r_dsp_rs2_tag;
    logic [TAG_W-1:0] r_dsp_rd_tag;

    assign w_inst = inst_from_if;
    assign w_opc  = w_inst[6:0];
    assign w_f3   = w_inst[14:12];
    assign w_f7   = w_inst[31:25];

    // Opcode/funct selection; anything unrecognised stays a NOP with no operands.
    always_comb begin
        w_op  = OP_NOP;
        w_fmt = FMT_NONE;
        case (w_opc)
            7'b0110111: begin w_op = OP_LUI;   w_fmt = FMT_U; end
            7'b0010111: begin w_op = OP_AUIPC; w_fmt = FMT_U; end
            7'b1101111: begin w_op = OP_JAL;   w_fmt = FMT_J; end
            7'b1100111: if (w_f3 == 3'b000) begin w_op = OP_JALR; w_fmt = FMT_I; end
            7'b1100011: begin
                w_fmt = FMT_B;
                case (w_f3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_fmt = FMT_NONE;
                endcase
            end
            7'b0000011: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000:  w_op = OP_LB;
                    3'b001:  w_op = OP_LH;
                    3'b010:  w_op = OP_LW;
                    3'b100:  w_op = OP_LBU;
                    3'b101:  w_op = OP_LHU;
                    default: w_fmt = FMT_NONE;
                endcase
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                case (w_f3)
                    3'b000:  w_op = OP_SB;
                    3'b001:  w_op = OP_SH;
                    3'b010:  w_op = OP_SW;
                    default: w_fmt = FMT_NONE;
                endcase
            end
            7'b0010011: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000: w_op = OP_ADDI;
                    3'b010: w_op = OP_SLTI;
                    3'b011: w_op = OP_SLTIU;
                    3'b100: w_op = OP_XORI;
                    3'b110: w_op = OP_ORI;
                    3'b111: w_op = OP_ANDI;
                    3'b001: begin
                        w_fmt = FMT_NONE;
                        if (w_f7 == 7'b0000000) begin w_op = OP_SLLI; w_fmt = FMT_SH; end
                    end
                    default: begin
                        w_fmt = FMT_NONE;
                        if (w_f7 == 7'b0000000) begin w_op = OP_SRLI; w_fmt = FMT_SH; end
                        if (w_f7 == 7'b0100000) begin w_op = OP_SRAI; w_fmt = FMT_SH; end
                    end
                endcase
            end
            7'b0110011: begin
                w_fmt = FMT_R;
                case ({w_f7, w_f3})
                    10'b0000000_000: w_op = OP_ADD;
                    10'b0100000_000: w_op = OP_SUB;
                    10'b0000000_001: w_op = OP_SLL;
                    10'b0000000_010: w_op = OP_SLT;
                    10'b0000000_011: w_op = OP_SLTU;
                    10'b0000000_100: w_op = OP_XOR;
                    10'b0000000_101: w_op = OP_SRL;
                    10'b0100000_101: w_op = OP_SRA;
                    10'b0000000_110: w_op = OP_OR;
                    10'b0000000_111: w_op = OP_AND;
                    default:         w_fmt = FMT_NONE;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rd  = '0;
        w_rs1 = '0;
        w_rs2 = '0;
        w_imm = '0;
        case (w_fmt)
            FMT_R:  begin w_rd = w_inst[11:7]; w_rs1 = w_inst[19:15]; w_rs2 = w_inst[24:20]; end
            FMT_I:  begin
                w_rd  = w_inst[11:7];
                w_rs1 = w_inst[19:15];
                w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            FMT_SH: begin w_rd = w_inst[11:7]; w_rs1 = w_inst[19:15]; w_imm = {27'd0, w_inst[24:20]}; end
            FMT_S:  begin
                w_rs1 = w_inst[19:15];
                w_rs2 = w_inst[24:20];
                w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            FMT_B:  begin
                w_rs1 = w_inst[19:15];
                w_rs2 = w_inst[24:20];
                w_imm = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
            end
            FMT_U:  begin w_rd = w_inst[11:7]; w_imm = {w_inst[31:12], 12'd0}; end
            FMT_J:  begin
                w_rd  = w_inst[11:7];
                w_imm = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // A commit whose tag matches the register's pending tag is forwarded as a ready value.
    assign w_rs1_hit = wb_valid && (wb_rd == w_rs1) && (wb_tag == r_tag[w_rs1]);
    assign w_rs2_hit = wb_valid && (wb_rd == w_rs2) && (wb_tag == r_tag[w_rs2]);
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : (w_rs1_hit ? wb_value : r_val[w_rs1]);
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : (w_rs2_hit ? wb_value : r_val[w_rs2]);
    assign w_rs1_tag = (w_rs1 == 5'd0 || w_rs1_hit) ? '0 : r_tag[w_rs1];
    assign w_rs2_tag = (w_rs2 == 5'd0 || w_rs2_hit) ? '0 : r_tag[w_rs2];

    assign dsp_ready = ~rs_full;
    assign w_fire    = inst_valid & ~rs_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every architectural register is cleared here so x1..x31 read 0 with tag 0 after reset.
            for (int i = 0; i < 32; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
            r_next_tag    <= TAG_W'(1);
            r_dsp_valid   <= 1'b0;
            r_dsp_op      <= OP_NOP;
            r_dsp_rd      <= '0;
            r_dsp_imm     <= '0;
            r_dsp_rs1_val <= '0;
            r_dsp_rs1_tag <= '0;
            r_dsp_rs2_val <= '0;
            r_dsp_rs2_tag <= '0;
            r_dsp_rd_tag  <= '0;
        end else begin
            if (wb_valid && wb_rd != 5'd0) begin
                r_val[wb_rd] <= wb_value;
                if (wb_tag == r_tag[wb_rd]) r_tag[wb_rd] <= '0;
            end
            // NOTE: this claim is the later non-blocking write, so it overrides a same-cycle tag clear.
            if (w_fire && w_rd != 5'd0) begin
                r_tag[w_rd] <= r_next_tag;
                r_next_tag  <= (r_next_tag == '1) ? TAG_W'(1) : r_next_tag + TAG_W'(1);
            end
            r_dsp_valid <= w_fire;
            if (w_fire) begin
                r_dsp_op      <= w_op;
                r_dsp_rd      <= w_rd;
                r_dsp_imm     <= w_imm;
                r_dsp_rs1_val <= w_rs1_val;
                r_dsp_rs1_tag <= w_rs1_tag;
                r_dsp_rs2_val <= w_rs2_val;
                r_dsp_rs2_tag <= w_rs2_tag;
                r_dsp_rd_tag  <= (w_rd != 5'd0) ? r_next_tag : '0;
            end
        end
    end

    assign dsp_valid   = r_dsp_valid;
    assign dsp_op_enum = r_dsp_op;
    assign dsp_rd      = r_dsp_rd;
    assign dsp_imm     = r_dsp_imm;
    assign dsp_rs1_val = r_dsp_rs1_val;
    assign dsp_rs1_tag = r_dsp_rs1_tag;
    assign dsp_rs2_val = r_dsp_rs2_val;
    assign dsp_rs2_tag = r_dsp_rs2_tag;
    assign dsp_rd_tag  = r_dsp_rd_tag;

endmodule

// File: tb/tb_decode_dispatch_unit.sv
// Bench for decode_dispatch_unit: expected packets are queued when an instruction is
// consumed and compared against each dsp_valid packet by a monitor.
module tb_decode_dispatch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst_from_if;
    logic        rs_full;
    logic        dsp_ready;
    logic        dsp_valid;
    logic [5:0]  dsp_op_enum;
    logic [4:0]  dsp_rd;
    logic [31:0] dsp_imm;
    logic [31:0] dsp_rs1_val;
    logic [3:0]  dsp_rs1_tag;
    logic [31:0] dsp_rs2_val;
    logic [3:0]  dsp_rs2_tag;
    logic [3:0]  dsp_rd_tag;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value;

    decode_dispatch_unit dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_from_if(inst_from_if),
        .rs_full(rs_full), .dsp_ready(dsp_ready), .dsp_valid(dsp_valid),
        .dsp_op_enum(dsp_op_enum), .dsp_rd(dsp_rd), .dsp_imm(dsp_imm),
        .dsp_rs1_val(dsp_rs1_val), .dsp_rs1_tag(dsp_rs1_tag),
        .dsp_rs2_val(dsp_rs2_val), .dsp_rs2_tag(dsp_rs2_tag), .dsp_rd_tag(dsp_rd_tag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_value(wb_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic [31:0] v2;
        logic [3:0]  t2;
        logic [3:0]  rdt;
    } pkt_t;

    pkt_t        sb[$];
    logic [31:0] m_val[32];
    logic [3:0]  m_tag[32];
    logic [3:0]  m_next;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        logic [31:0] t;
        t = imm;
        return {t[11:0], rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        logic [31:0] t;
        t = imm;
        return {t[11:5], rs2, rs1, f3, t[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_j(input int off, input logic [4:0] rd);
        logic [31:0] t;
        t = off;
        return {t[20], t[10:1], t[11], t[19:12], rd, 7'b1101111};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
        end
        m_next = 4'd1;
        sb.delete();
    endtask

    // One clock of stimulus; rd/rs1/rs2/imm are the fields the instruction is expected to decode to.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [5:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic wv, input logic [4:0] wrd, input logic [3:0] wtg, input logic [31:0] wval);
        pkt_t p;
        logic h1, h2;
        @(negedge clk);
        inst_valid   = v;
        inst_from_if = inst;
        wb_valid     = wv;
        wb_rd        = wrd;
        wb_tag       = wtg;
        wb_value     = wval;
        if (v && !rs_full) begin
            h1    = wv && (wrd == rs1) && (wtg == m_tag[rs1]);
            h2    = wv && (wrd == rs2) && (wtg == m_tag[rs2]);
            p.op  = op;
            p.rd  = rd;
            p.imm = imm;
            p.v1  = (rs1 == 0) ? 32'd0 : (h1 ? wval : m_val[rs1]);
            p.t1  = (rs1 == 0 || h1) ? 4'd0 : m_tag[rs1];
            p.v2  = (rs2 == 0) ? 32'd0 : (h2 ? wval : m_val[rs2]);
            p.t2  = (rs2 == 0 || h2) ? 4'd0 : m_tag[rs2];
            p.rdt = (rd != 0) ? m_next : 4'd0;
            sb.push_back(p);
        end
        if (wv && wrd != 0) begin
            m_val[wrd] = wval;
            if (wtg == m_tag[wrd]) m_tag[wrd] = 4'd0;
        end
        if (v && !rs_full && rd != 0) begin
            m_tag[rd] = m_next;
            m_next    = (m_next == 4'd15) ? 4'd1 : m_next + 4'd1;
        end
        @(posedge clk);
    endtask

    task automatic issue(input logic [31:0] inst, input logic [5:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        cycle(1'b1, inst, op, rd, rs1, rs2, imm, 1'b0, 5'd0, 4'd0, 32'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 32'd0);
    endtask

    task automatic wait_drain(input string name);
        idle();
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d packets never issued, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    always @(posedge clk) begin
        pkt_t e;
        #1;
        if (dsp_valid === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_packet: op=%0d rd=%0d with nothing pending", dsp_op_enum, dsp_rd);
            end else begin
                e = sb.pop_front();
                if (dsp_op_enum !== e.op || dsp_rd !== e.rd || dsp_imm !== e.imm ||
                    dsp_rs1_val !== e.v1 || dsp_rs1_tag !== e.t1 || dsp_rs2_val !== e.v2 ||
                    dsp_rs2_tag !== e.t2 || dsp_rd_tag !== e.rdt) begin
                    n_err++;
                    $display("FAIL packet: got op=%0d rd=%0d imm=%h v1=%h t1=%0d v2=%h t2=%0d rdt=%0d; need op=%0d rd=%0d imm=%h v1=%h t1=%0d v2=%h t2=%0d rdt=%0d",
                             dsp_op_enum, dsp_rd, dsp_imm, dsp_rs1_val, dsp_rs1_tag, dsp_rs2_val,
                             dsp_rs2_tag, dsp_rd_tag, e.op, e.rd, e.imm, e.v1, e.t1, e.v2, e.t2, e.rdt);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        n_vec++;
        if ({dsp_valid, dsp_op_enum, dsp_rd, dsp_imm, dsp_rs1_val, dsp_rs1_tag, dsp_rs2_val,
             dsp_rs2_tag, dsp_rd_tag} !== '0) begin
            n_err++;
            $display("FAIL %s: valid=%b op=%0d rd=%0d imm=%h rdt=%0d, required all zero",
                     name, dsp_valid, dsp_op_enum, dsp_rd, dsp_imm, dsp_rd_tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        n_vec++;
        if (dsp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b, required 1", dsp_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_decode_spec();
        issue(32'h00020137, 6'd1,  5'd2, 5'd0,  5'd0,  32'h00020000);
        issue(32'h02912223, 6'd18, 5'd0, 5'd2,  5'd9,  32'd36);
        issue(32'hfd010113, 6'd19, 5'd2, 5'd2,  5'd0,  32'hFFFFFFD0);
        issue(32'hfe891ae3, 6'd6,  5'd0, 5'd18, 5'd8,  -32'sd12);
        issue(32'h02412483, 6'd13, 5'd9, 5'd2,  5'd0,  32'd36);
        issue(32'hfd3a46e3, 6'd7,  5'd0, 5'd20, 5'd19, -32'sd52);
        wait_drain("decode_spec");
    endtask

    task automatic test_decode_formats();
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 6'd28, 5'd3, 5'd1, 5'd2, 32'd0);
        issue(enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4), 6'd29, 5'd4, 5'd3, 5'd1, 32'd0);
        issue(enc_r(7'h20, 5'd3, 5'd4, 3'b101, 5'd5), 6'd35, 5'd5, 5'd4, 5'd3, 32'd0);
        issue(enc_i(32'h403, 5'd5, 3'b101, 5'd6, 7'h13), 6'd27, 5'd6, 5'd5, 5'd0, 32'd3);
        issue(enc_i(31, 5'd6, 3'b001, 5'd6, 7'h13), 6'd25, 5'd6, 5'd6, 5'd0, 32'd31);
        issue(enc_j(-8, 5'd1), 6'd3, 5'd1, 5'd0, 5'd0, 32'hFFFFFFF8);
        issue({20'hFFFFF, 5'd13, 7'h17}, 6'd2, 5'd13, 5'd0, 5'd0, 32'hFFFFF000);
        issue(enc_s(-1, 5'd2, 5'd5, 3'b000), 6'd16, 5'd0, 5'd5, 5'd2, 32'hFFFFFFFF);
        issue(32'h0000007F, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        issue(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3), 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_drain("decode_formats");
    endtask

    task automatic test_writeback();
        logic [3:0] t;
        cycle(1'b0, 32'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd2, m_tag[2], 32'h1234);
        issue(enc_i(1, 5'd2, 3'b000, 5'd5, 7'h13), 6'd19, 5'd5, 5'd2, 5'd0, 32'd1);
        issue({20'h00001, 5'd6, 7'h37}, 6'd1, 5'd6, 5'd0, 5'd0, 32'h00001000);
        t = m_tag[6];
        cycle(1'b1, enc_r(7'h00, 5'd0, 5'd6, 3'b000, 5'd7), 6'd28, 5'd7, 5'd6, 5'd0, 32'd0,
              1'b1, 5'd6, t, 32'h55);
        t = m_tag[9] + 4'd1;
        cycle(1'b0, 32'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd9, t, 32'hBEEF);
        issue(enc_i(0, 5'd9, 3'b000, 5'd10, 7'h13), 6'd19, 5'd10, 5'd9, 5'd0, 32'd0);
        t = m_tag[9];
        cycle(1'b1, {20'h00002, 5'd9, 7'h37}, 6'd1, 5'd9, 5'd0, 5'd0, 32'h00002000,
              1'b1, 5'd9, t, 32'h77);
        issue(enc_r(7'h00, 5'd9, 5'd2, 3'b111, 5'd11), 6'd37, 5'd11, 5'd2, 5'd9, 32'd0);
        wait_drain("writeback");
    endtask

    task automatic test_stall();
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue({20'h00003, 5'd12, 7'h37}, 6'd1, 5'd12, 5'd0, 5'd0, 32'h00003000);
            #1;
            n_vec++;
            if (dsp_valid !== 1'b0 || dsp_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_%0d: valid=%b ready=%b, required 0/0", i, dsp_valid, dsp_ready);
            end
        end
        rs_full = 1'b0;
        issue(enc_i(5, 5'd12, 3'b000, 5'd13, 7'h13), 6'd19, 5'd13, 5'd12, 5'd0, 32'd5);
        wait_drain("stall");
    endtask

    task automatic test_tag_wrap();
        int wraps;
        logic [3:0] prev;
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            prev = m_next;
            issue(enc_i(i, 5'(1 + i % 15), 3'b000, 5'(1 + i % 15), 7'h13), 6'd19,
                  5'(1 + i % 15), 5'(1 + i % 15), 5'd0, 32'(i));
            if (prev == 4'd15) wraps++;
        end
        wait_drain("tag_wrap");
        n_vec++;
        if (wraps != 1) begin
            n_err++;
            $display("FAIL tag_wrap_coverage: wrap events %0d, required 1", wraps);
        end
    endtask

    task automatic test_reset_midstream();
        issue({20'h00004, 5'd7, 7'h37}, 6'd1, 5'd7, 5'd0, 5'd0, 32'h00004000);
        @(negedge clk);
        rst          = 1'b1;
        inst_valid   = 1'b1;
        inst_from_if = {20'h00005, 5'd8, 7'h37};
        @(posedge clk);
        #1;
        check_outputs_zero("reset_midstream");
        @(negedge clk);
        rst        = 1'b0;
        inst_valid = 1'b0;
        model_reset();
        issue(enc_i(0, 5'd7, 3'b000, 5'd8, 7'h13), 6'd19, 5'd8, 5'd7, 5'd0, 32'd0);
        wait_drain("after_reset");
    endtask

    initial begin
        rst          = 1'b1;
        inst_valid   = 1'b0;
        inst_from_if = '0;
        rs_full      = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_tag       = '0;
        wb_value     = '0;
        model_reset();
        test_reset();
        test_decode_spec();
        test_decode_formats();
        test_writeback();
        test_stall();
        test_tag_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
